// File: rtl/sc_exception_return.sv
// sc_exception_return: return side of the single-cycle MIPS exception path.
// Captures exceptions into EPC/Cause, tracks the handler level, exposes the
// CP0 registers via MFC0/MTC0 and redirects the PC to EPC on ERET.
module sc_exception_return #(
  parameter int COUNT_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        exception_taken,
  input  logic        undefined_instr,
  input  logic [31:0] epc_in,
  input  logic        eret,
  input  logic        mfc0,
  input  logic        mtc0,
  input  logic [4:0]  cp0_sel,
  input  logic [31:0] cp0_wdata,
  output logic        return_valid,
  output logic [31:0] return_pc,
  output logic [31:0] cp0_rdata,
  output logic        exl,
  output logic        eret_illegal,
  output logic        halt
);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_HANDLER = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  localparam logic [4:0] SEL_COUNT  = 5'd9;
  localparam logic [4:0] SEL_STATUS = 5'd12;
  localparam logic [4:0] SEL_CAUSE  = 5'd13;
  localparam logic [4:0] SEL_EPC    = 5'd14;

  localparam logic [4:0] EXC_UNDEF    = 5'd10;
  localparam logic [4:0] EXC_OVERFLOW = 5'd12;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [31:0]        epc_q, epc_d;
  logic [4:0]         exc_code_q, exc_code_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               exl_q, exl_d;
  logic               halt_q, halt_d;

  logic               wr_epc;
  logic               wr_count;
  logic [COUNT_W-1:0] count_base;
  logic [COUNT_W-1:0] count_inc;

  // Next-state logic: exceptions outrank ERET and MTC0; a Count clear issued
  // alongside an exception is applied before the increment, leaving 1.
  always_comb begin
    state_d    = state_q;
    epc_d      = epc_q;
    exc_code_d = exc_code_q;
    count_d    = count_q;
    wr_epc     = mtc0 && (cp0_sel == SEL_EPC);
    wr_count   = mtc0 && (cp0_sel == SEL_COUNT);
    count_base = wr_count ? '0 : count_q;
    count_inc  = (count_base == COUNT_MAX) ? count_base : count_base + COUNT_W'(1);
    if (enable) begin
      case (state_q)
        ST_NORMAL: begin
          if (exception_taken) begin
            state_d    = ST_HANDLER;
            epc_d      = epc_in;
            exc_code_d = undefined_instr ? EXC_UNDEF : EXC_OVERFLOW;
            count_d    = count_inc;
          end else begin
            if (wr_epc)   epc_d   = cp0_wdata;
            if (wr_count) count_d = '0;
          end
        end
        ST_HANDLER: begin
          if (exception_taken) begin
            state_d = ST_FAULT;
            count_d = count_inc;
          end else begin
            if (wr_epc)   epc_d   = cp0_wdata;
            if (wr_count) count_d = '0;
            if (eret)     state_d = ST_NORMAL;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_NORMAL;
      endcase
    end
    exl_d  = (state_d == ST_HANDLER);
    halt_d = (state_d == ST_FAULT);
  end

  // State and CP0 registers, with exl/halt registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_NORMAL;
      epc_q      <= '0;
      exc_code_q <= '0;
      count_q    <= '0;
      exl_q      <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      epc_q      <= epc_d;
      exc_code_q <= exc_code_d;
      count_q    <= count_d;
      exl_q      <= exl_d;
      halt_q     <= halt_d;
    end
  end

  // MFC0 read mux; reads see the registers as they stand before the edge.
  always_comb begin
    cp0_rdata = '0;
    if (mfc0) begin
      case (cp0_sel)
        SEL_STATUS: cp0_rdata = {30'b0, halt_q, exl_q};
        SEL_CAUSE:  cp0_rdata = {25'b0, exc_code_q, 2'b00};
        SEL_EPC:    cp0_rdata = epc_q;
        SEL_COUNT:  cp0_rdata = 32'(count_q);
        default:    cp0_rdata = '0;
      endcase
    end
  end

  assign exl          = exl_q;
  assign halt         = halt_q;
  assign return_pc    = epc_q;
  assign return_valid = eret && enable && (state_q == ST_HANDLER) && !exception_taken;
  assign eret_illegal = eret && enable && reset_n && (state_q == ST_NORMAL);

endmodule

// File: tb/tb_sc_exception_return.sv
// Scoreboard bench for sc_exception_return: the driver pushes the expected
// combinational response of every cycle, a negedge monitor pops and compares.
module tb_sc_exception_return;

  localparam int CNT_MAX = 255;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] rd;
    logic        exl;
    logic        halt;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        resetN;
  logic        enable;
  logic        excTaken;
  logic        undefInstr;
  logic [31:0] epcIn;
  logic        eret;
  logic        mfc0;
  logic        mtc0;
  logic [4:0]  cp0Sel;
  logic [31:0] cp0Wdata;
  logic        returnValid;
  logic [31:0] returnPc;
  logic [31:0] cp0Rdata;
  logic        exl;
  logic        eretIllegal;
  logic        halt;

  exp_t expQ[$];
  exp_t monExp;
  int   vectors;
  int   miscompares;

  // Reference model: plain flags and integers
  bit          mHandler;
  bit          mHalted;
  logic [31:0] mEpc;
  int          mCode;
  int          mCount;

  sc_exception_return #(.COUNT_W(8)) dut (
    .clk             (clk),
    .reset_n         (resetN),
    .enable          (enable),
    .exception_taken (excTaken),
    .undefined_instr (undefInstr),
    .epc_in          (epcIn),
    .eret            (eret),
    .mfc0            (mfc0),
    .mtc0            (mtc0),
    .cp0_sel         (cp0Sel),
    .cp0_wdata       (cp0Wdata),
    .return_valid    (returnValid),
    .return_pc       (returnPc),
    .cp0_rdata       (cp0Rdata),
    .exl             (exl),
    .eret_illegal    (eretIllegal),
    .halt            (halt)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] modelRead(input logic [4:0] sel);
    case (sel)
      5'd12:   return {30'b0, mHalted, mHandler};
      5'd13:   return 32'(mCode) << 2;
      5'd14:   return mEpc;
      5'd9:    return 32'(mCount);
      default: return 32'd0;
    endcase
  endfunction

  task automatic applyStimulus(input bit rst, input bit en, input bit exc, input bit und,
                               input logic [31:0] pc, input bit er, input bit mf,
                               input bit mt, input logic [4:0] sel, input logic [31:0] wd);
    exp_t e;
    int   c;
    @(posedge clk);
    #2;
    resetN = rst; enable = en; excTaken = exc; undefInstr = und; epcIn = pc;
    eret = er; mfc0 = mf; mtc0 = mt; cp0Sel = sel; cp0Wdata = wd;
    if (!rst) begin
      mHandler = 0; mHalted = 0; mEpc = 0; mCode = 0; mCount = 0;
    end
    e.exl  = mHandler;
    e.halt = mHalted;
    e.rpc  = mEpc;
    e.rv   = er && en && rst && mHandler && !exc;
    e.ill  = er && en && rst && !mHandler && !mHalted;
    e.rd   = mf ? modelRead(sel) : 32'd0;
    expQ.push_back(e);
    if (rst && en && !mHalted) begin
      if (exc) begin
        c = (mt && sel == 5'd9) ? 0 : mCount;
        mCount = (c + 1 > CNT_MAX) ? CNT_MAX : c + 1;
        if (mHandler) begin
          mHandler = 0;
          mHalted  = 1;
        end else begin
          mHandler = 1;
          mEpc     = pc;
          mCode    = und ? 10 : 12;
        end
      end else begin
        if (mt && sel == 5'd14) mEpc = wd;
        if (mt && sel == 5'd9)  mCount = 0;
        if (er && mHandler)     mHandler = 0;
      end
    end
  endtask

  task automatic cmpField(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    cmpField("return_valid", 32'(returnValid), 32'(e.rv));
    cmpField("return_pc", returnPc, e.rpc);
    cmpField("cp0_rdata", cp0Rdata, e.rd);
    cmpField("exl", 32'(exl), 32'(e.exl));
    cmpField("halt", 32'(halt), 32'(e.halt));
    cmpField("eret_illegal", 32'(eretIllegal), 32'(e.ill));
  endtask

  // Monitor: one expected response per driven cycle, compared mid-cycle
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      checkOutput(monExp);
    end
  end

  task automatic doIdle();
    applyStimulus(1, 1, 0, 0, 32'd0, 0, 0, 0, 5'd0, 32'd0);
  endtask
  task automatic doRead(input logic [4:0] sel);
    applyStimulus(1, 1, 0, 0, 32'd0, 0, 1, 0, sel, 32'd0);
  endtask
  task automatic doWrite(input logic [4:0] sel, input logic [31:0] wd);
    applyStimulus(1, 1, 0, 0, 32'd0, 0, 0, 1, sel, wd);
  endtask
  task automatic doExc(input bit und, input logic [31:0] pc);
    applyStimulus(1, 1, 1, und, pc, 0, 0, 0, 5'd0, 32'd0);
  endtask
  task automatic doEret();
    applyStimulus(1, 1, 0, 0, 32'd0, 1, 0, 0, 5'd0, 32'd0);
  endtask
  task automatic doReset(input logic [4:0] sel);
    applyStimulus(0, 1, 0, 0, 32'd0, 1, 1, 0, sel, 32'd0);
  endtask

  // Directed sequence, then randomized traffic with occasional resets
  initial begin
    logic [4:0] selTab [5];
    vectors = 0; miscompares = 0;
    mHandler = 0; mHalted = 0; mEpc = 0; mCode = 0; mCount = 0;
    resetN = 0; enable = 0; excTaken = 0; undefInstr = 0; epcIn = 0;
    eret = 0; mfc0 = 0; mtc0 = 0; cp0Sel = 0; cp0Wdata = 0;

    doReset(5'd9);
    doReset(5'd12);
    doExc(0, 32'h40);
    doRead(5'd14); doRead(5'd13); doRead(5'd9); doRead(5'd12);
    doWrite(5'd14, 32'h44);
    doEret();
    doRead(5'd12);
    doEret();
    doRead(5'd14);
    doExc(1, 32'h80);
    doExc(0, 32'hC0);
    doRead(5'd12); doRead(5'd14); doRead(5'd13);
    doEret();
    doWrite(5'd14, 32'h1234);
    doRead(5'd14);

    doReset(5'd14);
    applyStimulus(1, 0, 1, 0, 32'h100, 0, 0, 1, 5'd14, 32'h200);
    doRead(5'd14); doRead(5'd12); doRead(5'd9);
    applyStimulus(1, 1, 1, 0, 32'h100, 0, 0, 1, 5'd14, 32'h200);
    doRead(5'd14); doRead(5'd9);
    doEret();
    doWrite(5'd9, 32'hFFFF_FFFF);
    applyStimulus(1, 1, 1, 0, 32'h300, 0, 0, 1, 5'd9, 32'h0);
    doRead(5'd9);
    applyStimulus(1, 1, 1, 0, 32'h400, 1, 0, 0, 5'd0, 32'd0);
    doRead(5'd12);

    doReset(5'd9);
    for (int i = 0; i < 300; i++) begin
      doExc(i[0], 32'(i) << 2);
      doEret();
    end
    doRead(5'd9);
    doExc(0, 32'h500);
    doReset(5'd9);
    doReset(5'd12);
    doRead(5'd9);

    selTab[0] = 5'd9; selTab[1] = 5'd12; selTab[2] = 5'd13; selTab[3] = 5'd14;
    for (int i = 0; i < 1500; i++) begin
      selTab[4] = 5'($urandom);
      applyStimulus(($urandom_range(0, 39) != 0),
                    ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 5) == 0),
                    1'($urandom),
                    $urandom & 32'hFFFF_FFFC,
                    ($urandom_range(0, 3) == 0),
                    1'($urandom),
                    ($urandom_range(0, 3) == 0),
                    selTab[$urandom_range(0, 4)],
                    $urandom);
    end

    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sc_exception_return.md
# sc_exception_return

Return side of the single-cycle MIPS exception path. It captures the exception reported by the exception controller, tracks handler state (exception level) and exposes EPC/Cause/Status to software via MFC0/MTC0. On ERET it redirects the PC back to the saved EPC. It sits beside `sc_exception_control` and feeds the PC-next mux, the register-file write-back mux and the core halt logic.

## Interface
Parameters:
- `COUNT_W`, 8, width of the saturating exception counter.

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low; one clock domain.
- `enable`  in  1  core advance enable; all state updates are qualified by it.
- `exception_taken`  in  1  exception this cycle (the controller's EPC-write strobe).
- `undefined_instr`  in  1  cause qualifier: undefined instruction when high, otherwise overflow.
- `epc_in`  in  32  PC of the faulting instruction.
- `eret`  in  1  ERET decoded this cycle.
- `mfc0`  in  1  MFC0 decoded this cycle.
- `mtc0`  in  1  MTC0 decoded this cycle.
- `cp0_sel`  in  5  CP0 register number (rd field).
- `cp0_wdata`  in  32  MTC0 data (rt value).
- `return_valid`  out  1  PC-next mux select: take `return_pc`.
- `return_pc`  out  32  ERET target (current EPC register).
- `cp0_rdata`  out  32  MFC0 read data.
- `exl`  out  1  handler active.
- `eret_illegal`  out  1  ERET executed outside a handler (combinational pulse).
- `halt`  out  1  double fault; sticky until reset.

## Operation
- State machine: NORMAL (exl=0), HANDLER (exl=1), FAULT (halt=1).
  - NORMAL: `exception_taken` -> HANDLER. EPC <= `epc_in`; Cause.ExcCode <= 10 if `undefined_instr`, else 12; counter increments.
  - HANDLER: `eret` -> NORMAL. `exception_taken` -> FAULT; EPC and Cause are unchanged, counter increments.
  - FAULT: absorbing. Ignores all inputs except reset and MFC0 reads.
- CP0 map, read as `cp0_rdata` when `mfc0`, otherwise 0:
  - 12 Status = {30'b0, halt, exl}, read-only.
  - 13 Cause = {25'b0, ExcCode[4:0], 2'b0}; MTC0 writes are ignored.
  - 14 EPC, read/write. MTC0 lets the handler skip the faulting instruction (EPC+4).
  - 9 Count = zero-extended saturating counter; MTC0 writes clear it to 0 regardless of data.
  - Any other number reads 0; writes are dropped.
- `return_valid` = `eret` & `enable` & state==HANDLER & !`exception_taken`. `return_pc` always equals EPC.
- `eret_illegal` = `eret` & `enable` & state==NORMAL. There is no redirect and no state change; the core treats the instruction as a NOP.
- Priority within one cycle, highest first:
  - `exception_taken` beats `eret` and `mtc0`. The EPC capture wins over an MTC0 to EPC.
  - In HANDLER, `exception_taken` together with `eret` -> FAULT and `return_valid`=0.
- Counter saturates at 2^COUNT_W−1. An MTC0 clear in the same cycle as an increment results in 1.

## Timing
- Reset, asynchronous, while `reset_n`=0:
  - state=NORMAL; EPC=0, Cause=0, Count=0.
  - Outputs: exl=0, halt=0, return_valid=0, return_pc=0, cp0_rdata=0, eret_illegal=0.
- Reset assertion mid-handler or in FAULT clears state immediately, without waiting for a clock edge.
- Register updates are visible in the cycle after the edge. MFC0 in the same cycle as the capturing edge reads the old value; there is no write-through.
- `return_valid`, `return_pc`, `cp0_rdata` and `eret_illegal` are combinational from current state and inputs: zero-latency redirect for the single-cycle PC mux.
- With `enable`=0: no register or state changes; `return_valid`=0 and `eret_illegal`=0; `cp0_rdata` still reflects the current registers.

## Test plan
- Reset, then overflow at `epc_in`=0x0000_0040 -> next cycle exl=1, MFC0 14 = 0x40, MFC0 13 = 0x30, MFC0 9 = 1.
- In HANDLER: MTC0 14 ← 0x44, then ERET -> ERET cycle `return_valid`=1, `return_pc`=0x44; next cycle exl=0.
- ERET in NORMAL -> `eret_illegal`=1, `return_valid`=0, exl stays 0, EPC unchanged.
- Undefined at 0x80, then overflow at 0xC0 while in HANDLER -> halt=1, MFC0 14 = 0x80, MFC0 13 = 0x28; a following ERET gives `return_valid`=0.
- Same-cycle exception at 0x100 + MTC0 14 ← 0x200 in NORMAL -> EPC=0x100. With `enable`=0 for a cycle, the same stimulus changes nothing.
- Drive 300 exception/ERET pairs (COUNT_W=8) -> Count=255. Then deassert `reset_n` mid-handler -> exl, halt and Count read 0 asynchronously.
